sa_cache_core: RTL
==================

SA_CACHE_CORE -- requirements
Module: sa_cache_core

Interface
REQ-001 SHALL have parameter SETS, default 256, number of sets (power of 2).
REQ-002 SHALL have parameter WAYS, default 4, associativity (power of 2, 2..16).
REQ-003 SHALL have parameter TAG_BITS, default 18, tag width.
REQ-004 SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-005 SHALL have parameter WORDS_PER_LINE, default 16, words per line (power of 2).
REQ-006 SHALL have ports clk (in, 1, the single clock) and rst (in, 1, reset, asynchronous, active-high).
REQ-007 SHALL have req_valid/req_ready (in/out, 1, request handshake) and req_we (in, 1, 1 = write).
REQ-008 SHALL have req_tag (in, TAG_BITS), req_index (in, clog2(SETS)), req_word (in, clog2(WORDS_PER_LINE)) and req_wdata (in, DATA_WIDTH).
REQ-009 SHALL have resp_valid (out, 1, one-cycle pulse), resp_hit (out, 1, lookup hit) and resp_rdata (out, DATA_WIDTH).
REQ-010 SHALL have mem_cmd_valid/mem_cmd_ready (out/in, 1), mem_cmd_we (out, 1) and mem_cmd_addr (out, TAG_BITS+clog2(SETS), line address {tag,index}).
REQ-011 SHALL have mem_wvalid/mem_wready (out/in, 1) and mem_wdata (out, DATA_WIDTH) for writeback beats.
REQ-012 SHALL have mem_rvalid (in, 1) and mem_rdata (in, DATA_WIDTH) for refill beats (no backpressure).

Function
REQ-013 SHALL use states IDLE, LOOKUP, WB_CMD, WB_DATA, RF_CMD, RF_DATA, RESPOND.
REQ-014 SHALL assert req_ready only in IDLE and, on req_valid&&req_ready, register the request and go to LOOKUP.
REQ-015 In LOOKUP, SHALL compare the tag against all WAYS valid ways in parallel; hit = valid && tag match; at most one way hits.
REQ-016 On hit, SHALL read or write the addressed word, set dirty on write, update PLRU, and go to RESPOND; resp_valid SHALL pulse exactly 2 cycles after the acceptance edge.
REQ-017 On miss, SHALL choose the victim as the lowest-index invalid way, otherwise the tree-PLRU victim (WAYS-1 bits per set).
REQ-018 If the victim is valid and dirty, SHALL go to WB_CMD, otherwise to RF_CMD.
REQ-019 WB_CMD SHALL hold mem_cmd_valid=1, mem_cmd_we=1 and addr={victim tag,index} until mem_cmd_ready; WB_DATA SHALL send words 0..WORDS_PER_LINE-1 in order, advancing on mem_wvalid&&mem_wready, then go to RF_CMD.
REQ-020 RF_CMD SHALL issue mem_cmd_we=0 with addr={req_tag,index}; RF_DATA SHALL store words 0..N-1 in order, one per mem_rvalid cycle, then go to RESPOND.
REQ-021 On refill completion, SHALL set the line valid with the new tag and dirty=req_we, merge a pending write word, and update PLRU to mark the way most recently used.
REQ-022 In RESPOND, SHALL assert resp_valid for one cycle with resp_hit from LOOKUP and resp_rdata = the addressed word (post-write value on writes), then return to IDLE.
REQ-023 The beat counter SHALL be clog2(WORDS_PER_LINE) bits wide and wrap to 0 at the end of each burst.
REQ-024 mem_rvalid outside RF_DATA and mem_wready/mem_cmd_ready outside their states SHALL be ignored.
REQ-025 mem_cmd_valid SHALL NOT deassert before mem_cmd_ready once asserted.

Reset
REQ-026 On rst, SHALL clear all valid, dirty and PLRU bits and set state to IDLE and the beat counter to 0; tag/data arrays need no reset.
REQ-027 While rst is high, outputs SHALL be req_ready=0, resp_valid=0, resp_hit=0, resp_rdata=0, mem_cmd_valid=0, mem_cmd_we=0, mem_cmd_addr=0, mem_wvalid=0 and mem_wdata=0; req_ready SHALL be 1 in the first cycle after release.
REQ-028 A reset mid-burst SHALL abandon the transfer without a response; a partial line SHALL never be marked valid.

Structure
REQ-029 The shared package sa_cache_pkg SHALL hold the state enum and the clog2-derived width constants.
REQ-030 The PLRU tree update and victim selection SHALL live in sub-module sa_cache_plru (parameter WAYS).

Verification
REQ-031 Read 0x3/idx5/word2 after reset -> miss: RF_CMD addr={0x3,5}, 16 beats of data k=0x100+k, resp_hit=0, resp_rdata=0x102.
REQ-032 Repeat the same read -> resp_valid 2 cycles after acceptance, resp_hit=1, resp_rdata=0x102, no mem_cmd.
REQ-033 Write 0xDEAD to a hit line, then fill tags 0x4..0x7 in idx5 -> the 4th fill writes back the dirty victim (mem_cmd_we=1, word2=0xDEAD) before refilling.
REQ-034 Stall mem_wready 3 cycles per beat -> mem_wdata holds and exactly 16 beats are sent.
REQ-035 Assert rst during beat 7 of RF_DATA -> all outputs are 0, and a re-read of the same address misses.

Source files
------------

// File: rtl/sa_cache_pkg.sv
// Shared types and width helpers for the set-associative cache core.
package sa_cache_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StWbCmd,
    StWbData,
    StRfCmd,
    StRfData,
    StRespond
  } state_e;

  localparam int unsigned DefSets         = 256;
  localparam int unsigned DefWays         = 4;
  localparam int unsigned DefTagBits      = 18;
  localparam int unsigned DefDataWidth    = 32;
  localparam int unsigned DefWordsPerLine = 16;

  // Address-field widths for a given geometry
  function automatic int unsigned width_of(int unsigned n);
    return $clog2(n);
  endfunction

  localparam int unsigned DefIdxW  = width_of(DefSets);
  localparam int unsigned DefWordW = width_of(DefWordsPerLine);
  localparam int unsigned DefWayW  = width_of(DefWays);

endpackage

// File: rtl/sa_cache_plru.sv
// Tree pseudo-LRU: victim walk and most-recently-used update for one set.
// Node n of the heap (root = 1) is stored at bit n-1; a bit value of 1
// means the victim lies in the right (higher-numbered) subtree.
module sa_cache_plru #(
  parameter int unsigned WAYS = 4
) (
  input  logic [WAYS-2:0]         plru_i,
  input  logic [$clog2(WAYS)-1:0] touch_way_i,
  output logic [WAYS-2:0]         plru_o,
  output logic [$clog2(WAYS)-1:0] victim_o
);

  localparam int unsigned WayW = $clog2(WAYS);

  // Follow the tree bits from the root down to the least recently used leaf
  always_comb begin
    int unsigned node;
    logic        b;
    node = 1;
    for (int l = 0; l < int'(WayW); l++) begin
      b    = plru_i[WayW'(node - 1)];
      node = 2 * node + 32'(b);
    end
    victim_o = WayW'(node - WAYS);
  end

  // Point every node on the touched path away from the touched way
  always_comb begin
    int unsigned         node;
    logic [WayW-1:0]     path;
    logic                b;
    plru_o = plru_i;
    node   = 1;
    path   = touch_way_i;
    for (int l = 0; l < int'(WayW); l++) begin
      b                        = path[WayW-1];
      path                     = path << 1;
      plru_o[WayW'(node - 1)]  = ~b;
      node                     = 2 * node + 32'(b);
    end
  end

endmodule

// File: rtl/sa_cache_core.sv
// Blocking set-associative write-back cache with tree-PLRU replacement.
module sa_cache_core
  import sa_cache_pkg::*;
#(
  parameter int unsigned SETS           = DefSets,
  parameter int unsigned WAYS           = DefWays,
  parameter int unsigned TAG_BITS       = DefTagBits,
  parameter int unsigned DATA_WIDTH     = DefDataWidth,
  parameter int unsigned WORDS_PER_LINE = DefWordsPerLine
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic                                  req_we,
  input  logic [TAG_BITS-1:0]                   req_tag,
  input  logic [$clog2(SETS)-1:0]               req_index,
  input  logic [$clog2(WORDS_PER_LINE)-1:0]     req_word,
  input  logic [DATA_WIDTH-1:0]                 req_wdata,
  output logic                                  resp_valid,
  output logic                                  resp_hit,
  output logic [DATA_WIDTH-1:0]                 resp_rdata,
  output logic                                  mem_cmd_valid,
  input  logic                                  mem_cmd_ready,
  output logic                                  mem_cmd_we,
  output logic [TAG_BITS+$clog2(SETS)-1:0]      mem_cmd_addr,
  output logic                                  mem_wvalid,
  input  logic                                  mem_wready,
  output logic [DATA_WIDTH-1:0]                 mem_wdata,
  input  logic                                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0]                 mem_rdata
);

  localparam int unsigned IdxW  = width_of(SETS);
  localparam int unsigned WordW = width_of(WORDS_PER_LINE);
  localparam int unsigned WayW  = width_of(WAYS);
  localparam logic [WordW-1:0] LastBeat = WordW'(WORDS_PER_LINE - 1);

  logic [TAG_BITS-1:0]   tag_q  [SETS][WAYS];
  logic [DATA_WIDTH-1:0] data_q [SETS][WAYS][WORDS_PER_LINE];
  logic [WAYS-1:0]       valid_q [SETS];
  logic [WAYS-1:0]       dirty_q [SETS];
  logic [WAYS-2:0]       plru_q  [SETS];

  state_e                state_q, state_d;
  logic [WordW-1:0]      cnt_q, cnt_d;
  logic [WayW-1:0]       way_q, way_d;
  logic                  hit_q, hit_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [TAG_BITS-1:0]   rq_tag_q, rq_tag_d;
  logic [IdxW-1:0]       rq_idx_q, rq_idx_d;
  logic [WordW-1:0]      rq_word_q, rq_word_d;
  logic                  rq_we_q, rq_we_d;
  logic [DATA_WIDTH-1:0] rq_wdata_q, rq_wdata_d;

  logic [WAYS-1:0]       hit_vec;
  logic                  hit_any;
  logic [WayW-1:0]       hit_way, inv_way, plru_victim, victim, touch_way;
  logic                  inv_found;
  logic [WAYS-2:0]       plru_next;

  logic                  data_we, plru_we, dirty_we, fill_done;
  logic [WordW-1:0]      data_word;
  logic [DATA_WIDTH-1:0] data_wdata;
  logic [WayW-1:0]       data_way;

  // Parallel tag compare and victim choice for the registered request's set
  always_comb begin
    hit_way   = '0;
    inv_way   = '0;
    inv_found = 1'b0;
    for (int w = 0; w < int'(WAYS); w++) begin
      hit_vec[w] = valid_q[rq_idx_q][w] && (tag_q[rq_idx_q][w] == rq_tag_q);
    end
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WayW'(w);
      if (!valid_q[rq_idx_q][w]) begin
        inv_way   = WayW'(w);
        inv_found = 1'b1;
      end
    end
    hit_any   = |hit_vec;
    victim    = inv_found ? inv_way : plru_victim;
    touch_way = (state_q == StLookup) ? hit_way : way_q;
  end

  sa_cache_plru #(
    .WAYS(WAYS)
  ) u_plru (
    .plru_i     (plru_q[rq_idx_q]),
    .touch_way_i(touch_way),
    .plru_o     (plru_next),
    .victim_o   (plru_victim)
  );

  // Controller next-state and array write enables
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    way_d      = way_q;
    hit_d      = hit_q;
    rdata_d    = rdata_q;
    rq_tag_d   = rq_tag_q;
    rq_idx_d   = rq_idx_q;
    rq_word_d  = rq_word_q;
    rq_we_d    = rq_we_q;
    rq_wdata_d = rq_wdata_q;
    data_we    = 1'b0;
    data_way   = way_q;
    data_word  = cnt_q;
    data_wdata = mem_rdata;
    plru_we    = 1'b0;
    dirty_we   = 1'b0;
    fill_done  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          rq_tag_d   = req_tag;
          rq_idx_d   = req_index;
          rq_word_d  = req_word;
          rq_we_d    = req_we;
          rq_wdata_d = req_wdata;
          state_d    = StLookup;
        end
      end
      StLookup: begin
        hit_d = hit_any;
        if (hit_any) begin
          way_d   = hit_way;
          plru_we = 1'b1;
          rdata_d = data_q[rq_idx_q][hit_way][rq_word_q];
          if (rq_we_q) begin
            data_we    = 1'b1;
            data_way   = hit_way;
            data_word  = rq_word_q;
            data_wdata = rq_wdata_q;
            dirty_we   = 1'b1;
            rdata_d    = rq_wdata_q;
          end
          state_d = StRespond;
        end else begin
          way_d   = victim;
          cnt_d   = '0;
          state_d = (valid_q[rq_idx_q][victim] && dirty_q[rq_idx_q][victim]) ? StWbCmd : StRfCmd;
        end
      end
      StWbCmd: if (mem_cmd_ready) state_d = StWbData;
      StWbData: begin
        if (mem_wready) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastBeat) state_d = StRfCmd;
        end
      end
      StRfCmd: if (mem_cmd_ready) state_d = StRfData;
      StRfData: begin
        if (mem_rvalid) begin
          data_we = 1'b1;
          // A pending write replaces its word as the line streams in
          if (rq_we_q && cnt_q == rq_word_q) data_wdata = rq_wdata_q;
          if (cnt_q == rq_word_q) rdata_d = data_wdata;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastBeat) begin
            fill_done = 1'b1;
            plru_we   = 1'b1;
            state_d   = StRespond;
          end
        end
      end
      StRespond: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Control state and per-set status bits; valid only rises once a full line has arrived
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      way_q      <= '0;
      hit_q      <= 1'b0;
      rdata_q    <= '0;
      rq_tag_q   <= '0;
      rq_idx_q   <= '0;
      rq_word_q  <= '0;
      rq_we_q    <= 1'b0;
      rq_wdata_q <= '0;
      for (int s = 0; s < int'(SETS); s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      way_q      <= way_d;
      hit_q      <= hit_d;
      rdata_q    <= rdata_d;
      rq_tag_q   <= rq_tag_d;
      rq_idx_q   <= rq_idx_d;
      rq_word_q  <= rq_word_d;
      rq_we_q    <= rq_we_d;
      rq_wdata_q <= rq_wdata_d;
      if (plru_we) plru_q[rq_idx_q] <= plru_next;
      if (dirty_we) dirty_q[rq_idx_q][touch_way] <= 1'b1;
      if (fill_done) begin
        valid_q[rq_idx_q][way_q] <= 1'b1;
        dirty_q[rq_idx_q][way_q] <= rq_we_q;
      end
    end
  end

  // Tag and data storage, no reset
  always_ff @(posedge clk) begin
    if (data_we) data_q[rq_idx_q][data_way][data_word] <= data_wdata;
    if (fill_done) tag_q[rq_idx_q][way_q] <= rq_tag_q;
  end

  // Outputs decoded from registered state; everything is zero while in reset
  always_comb begin
    req_ready     = (state_q == StIdle) && !rst;
    resp_valid    = (state_q == StRespond);
    resp_hit      = (state_q == StRespond) && hit_q;
    resp_rdata    = (state_q == StRespond) ? rdata_q : '0;
    mem_cmd_valid = (state_q == StWbCmd) || (state_q == StRfCmd);
    mem_cmd_we    = (state_q == StWbCmd);
    mem_cmd_addr  = '0;
    if (state_q == StWbCmd) mem_cmd_addr = {tag_q[rq_idx_q][way_q], rq_idx_q};
    if (state_q == StRfCmd) mem_cmd_addr = {rq_tag_q, rq_idx_q};
    mem_wvalid    = (state_q == StWbData);
    mem_wdata     = (state_q == StWbData) ? data_q[rq_idx_q][way_q][cnt_q] : '0;
  end

endmodule
